// File: rtl/cp0_regfile_pkg.sv
// rtl/cp0_regfile_pkg.sv - shared CP0 exception codes, register numbers, field positions and masks
//
// Purpose: one place for every constant both the exception detector and the
//          CP0 register file must agree on.
// Ports:   none (package).
package cp0_regfile_pkg;

    // Resolved exception type codes, as produced by the MEM-stage detector
    localparam logic [31:0] EXC_TYPE_NOEXC = 32'h0000_0000;
    localparam logic [31:0] EXC_TYPE_INT   = 32'h0000_0001;
    localparam logic [31:0] EXC_TYPE_ADEL  = 32'h0000_0004;
    localparam logic [31:0] EXC_TYPE_ADES  = 32'h0000_0005;
    localparam logic [31:0] EXC_TYPE_SYS   = 32'h0000_0008;
    localparam logic [31:0] EXC_TYPE_BP    = 32'h0000_0009;
    localparam logic [31:0] EXC_TYPE_RI    = 32'h0000_000a;
    localparam logic [31:0] EXC_TYPE_OV    = 32'h0000_000c;
    localparam logic [31:0] EXC_TYPE_ERET  = 32'h0000_000e;

    // CP0 register numbers
    localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC      = 5'd14;
    localparam logic [4:0] CP0_REG_PRID     = 5'd15;
    localparam logic [4:0] CP0_REG_CONFIG   = 5'd16;

    // Status / Cause field positions
    localparam int STATUS_IE          = 0;
    localparam int STATUS_EXL         = 1;
    localparam int STATUS_BEV         = 22;
    localparam int CAUSE_EXCCODE_LSB  = 2;
    localparam int CAUSE_EXCCODE_MSB  = 6;
    localparam int CAUSE_IP_SW_LSB    = 8;
    localparam int CAUSE_IP_SW_MSB    = 9;
    localparam int CAUSE_IP_HW_LSB    = 10;
    localparam int CAUSE_IP_HW_MSB    = 15;
    localparam int CAUSE_BD           = 31;

    // Software-writable bits and hard-wired ones
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] STATUS_FIXED = 32'h0040_0000;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    typedef enum logic [4:0] {
        EXCCODE_INT  = 5'h00,
        EXCCODE_ADEL = 5'h04,
        EXCCODE_ADES = 5'h05,
        EXCCODE_SYS  = 5'h08,
        EXCCODE_BP   = 5'h09,
        EXCCODE_RI   = 5'h0a,
        EXCCODE_OV   = 5'h0c
    } exccode_e;

    // Map a detector exception type to the architectural Cause.ExcCode
    function automatic exccode_e exc_code(input logic [31:0] exc_type);
        exccode_e code;
        case (exc_type)
            EXC_TYPE_ADEL: code = EXCCODE_ADEL;
            EXC_TYPE_ADES: code = EXCCODE_ADES;
            EXC_TYPE_SYS:  code = EXCCODE_SYS;
            EXC_TYPE_BP:   code = EXCCODE_BP;
            EXC_TYPE_RI:   code = EXCCODE_RI;
            EXC_TYPE_OV:   code = EXCCODE_OV;
            default:       code = EXCCODE_INT;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - CP0 Count/Compare timer with sticky timer interrupt
//
// Purpose: half-rate Count, Compare match detection, timer interrupt.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   count_we          load Count from wdata this cycle (wins over increment)
//   compare_we        load Compare from wdata and clear timer_int
//   wdata             write data
//   count, compare    live register values
//   timer_int         timer interrupt pending
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    logic tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick      <= 1'b0;
            count     <= 32'h0;
            compare   <= 32'h0;
            timer_int <= 1'b0;
        end else begin
            tick <= ~tick;

            if (count_we) begin
                count <= wdata;
            end else if (tick) begin
                count <= count + 32'd1;
            end

            if (compare_we) begin
                compare <= wdata;
            end

            // A Compare write acknowledges the interrupt and beats a
            // same-cycle match. Compare==0 is treated as "timer off".
            if (compare_we) begin
                timer_int <= 1'b0;
            end else if ((compare != 32'h0) && (count == compare)) begin
                timer_int <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_regfile.sv
// rtl/cp0_regfile.sv - CP0 register file: exception commit, mfc0/mtc0, timer
//
// Purpose: holds Status/Cause/EPC/BadVAddr, commits MEM-stage exceptions and
//          eret, serves mfc0 (with same-cycle mtc0 bypass) and mtc0.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   we_i, waddr_i, data_i         mtc0 commit
//   raddr_i, data_o               mfc0 read (combinational)
//   ext_int_i                     hardware interrupt lines -> Cause.IP[15:10]
//   except_type_i, pc_i,
//   is_in_delayslot_i, badvaddr_i resolved exception from the detector
//   status_o .. compare_o         live registered values
//   timer_int_o                   timer interrupt pending
module cp0_regfile
    import cp0_regfile_pkg::*;
#(
    parameter logic [31:0] PRID_VAL   = 32'h0000_4220,
    parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  ext_int_i,
    input  logic [31:0] except_type_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] badvaddr_i,
    output logic [31:0] data_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic        is_eret;
    logic        is_exc;
    logic        wr;
    logic        exl;
    logic        bypass;
    logic [31:0] status_wval;
    logic [31:0] cause_wval;
    exccode_e    code;

    assign is_eret = (except_type_i == EXC_TYPE_ERET);
    assign is_exc  = (except_type_i != EXC_TYPE_NOEXC) && !is_eret;
    // The mtc0 belongs to an instruction being flushed by the exception/eret
    assign wr      = we_i && !is_exc && !is_eret;
    assign exl     = status_o[STATUS_EXL];
    assign code    = exc_code(except_type_i);

    assign status_wval = (data_i & STATUS_WMASK) | STATUS_FIXED;
    assign cause_wval  = (cause_o & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);

    cp0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (wr && (waddr_i == CP0_REG_COUNT)),
        .compare_we (wr && (waddr_i == CP0_REG_COMPARE)),
        .wdata      (data_i),
        .count      (count_o),
        .compare    (compare_o),
        .timer_int  (timer_int_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            status_o <= STATUS_FIXED;
        end else if (is_exc) begin
            status_o[STATUS_EXL] <= 1'b1;
        end else if (is_eret) begin
            status_o[STATUS_EXL] <= 1'b0;
        end else if (wr && (waddr_i == CP0_REG_STATUS)) begin
            status_o <= status_wval;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cause_o <= 32'h0;
        end else begin
            // Hardware IP tracks the pins every cycle; IP7 also carries the timer
            cause_o[CAUSE_IP_HW_MSB:CAUSE_IP_HW_LSB] <= {ext_int_i[5] | timer_int_o, ext_int_i[4:0]};
            if (wr && (waddr_i == CP0_REG_CAUSE)) begin
                cause_o[CAUSE_IP_SW_MSB:CAUSE_IP_SW_LSB] <= data_i[CAUSE_IP_SW_MSB:CAUSE_IP_SW_LSB];
            end
            if (is_exc) begin
                cause_o[CAUSE_EXCCODE_MSB:CAUSE_EXCCODE_LSB] <= code;
                // Nested exceptions keep the original BD/EPC pair
                if (!exl) begin
                    cause_o[CAUSE_BD] <= is_in_delayslot_i;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            epc_o <= 32'h0;
        end else if (is_exc) begin
            if (!exl) begin
                epc_o <= is_in_delayslot_i ? (pc_i - 32'd4) : pc_i;
            end
        end else if (wr && (waddr_i == CP0_REG_EPC)) begin
            epc_o <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr_o <= 32'h0;
        end else if (is_exc && ((except_type_i == EXC_TYPE_ADEL) || (except_type_i == EXC_TYPE_ADES))) begin
            badvaddr_o <= badvaddr_i;
        end else if (wr && (waddr_i == CP0_REG_BADVADDR)) begin
            badvaddr_o <= data_i;
        end
    end

    // mfc0 sees the value an mtc0 to the same register is writing right now
    assign bypass = we_i && (waddr_i == raddr_i);

    always_comb begin
        data_o = 32'h0;
        case (raddr_i)
            CP0_REG_BADVADDR: data_o = bypass ? data_i      : badvaddr_o;
            CP0_REG_COUNT:    data_o = bypass ? data_i      : count_o;
            CP0_REG_COMPARE:  data_o = bypass ? data_i      : compare_o;
            CP0_REG_STATUS:   data_o = bypass ? status_wval : status_o;
            CP0_REG_CAUSE:    data_o = bypass ? cause_wval  : cause_o;
            CP0_REG_EPC:      data_o = bypass ? data_i      : epc_o;
            CP0_REG_PRID:     data_o = PRID_VAL;
            CP0_REG_CONFIG:   data_o = CONFIG_VAL;
            default:          data_o = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// tb/tb_cp0_regfile.sv - scoreboard bench for cp0_regfile
module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_i;
    logic [5:0]  ext_int_i;
    logic [31:0] except_type_i;
    logic [31:0] pc_i;
    logic        is_in_delayslot_i;
    logic [31:0] badvaddr_i;
    logic [31:0] data_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] badvaddr_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic        timer_int_o;

    cp0_regfile dut (
        .clk               (clk),
        .rst               (rst),
        .we_i              (we_i),
        .waddr_i           (waddr_i),
        .raddr_i           (raddr_i),
        .data_i            (data_i),
        .ext_int_i         (ext_int_i),
        .except_type_i     (except_type_i),
        .pc_i              (pc_i),
        .is_in_delayslot_i (is_in_delayslot_i),
        .badvaddr_i        (badvaddr_i),
        .data_o            (data_o),
        .status_o          (status_o),
        .cause_o           (cause_o),
        .epc_o             (epc_o),
        .badvaddr_o        (badvaddr_o),
        .count_o           (count_o),
        .compare_o         (compare_o),
        .timer_int_o       (timer_int_o)
    );

    always #5 clk = ~clk;

    localparam int SEL_READ   = 0;
    localparam int SEL_STATUS = 1;
    localparam int SEL_CAUSE  = 2;
    localparam int SEL_EPC    = 3;
    localparam int SEL_BADV   = 4;
    localparam int SEL_COUNT  = 5;
    localparam int SEL_CMP    = 6;
    localparam int SEL_TINT   = 7;

    typedef struct {
        string       tag;
        int          sel;
        logic [4:0]  addr;
        logic [31:0] mask;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [4:0] addr,
                        input logic [31:0] mask, input logic [31:0] exp);
        exp_t e;
        e.tag = tag; e.sel = sel; e.addr = addr; e.mask = mask; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] got;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel == SEL_READ) begin
                raddr_i = e.addr;
                #1;
            end
            case (e.sel)
                SEL_READ:   got = data_o;
                SEL_STATUS: got = status_o;
                SEL_CAUSE:  got = cause_o;
                SEL_EPC:    got = epc_o;
                SEL_BADV:   got = badvaddr_o;
                SEL_COUNT:  got = count_o;
                SEL_CMP:    got = compare_o;
                default:    got = {31'h0, timer_int_o};
            endcase
            check_val(e.tag, got & e.mask, e.exp & e.mask);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; data_i = d;
        step();
        we_i = 1'b0;
    endtask

    task automatic except(input logic [31:0] t, input logic [31:0] pc, input logic ds, input logic [31:0] bv);
        except_type_i = t; pc_i = pc; is_in_delayslot_i = ds; badvaddr_i = bv;
        step();
        except_type_i = 32'h0; is_in_delayslot_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=%0d exp=finished", total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1; we_i = 1'b0; waddr_i = 5'd0; raddr_i = 5'd0; data_i = 32'h0;
        ext_int_i = 6'h0; except_type_i = 32'h0; pc_i = 32'h0;
        is_in_delayslot_i = 1'b0; badvaddr_i = 32'h0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        push("rst_status_rd", SEL_READ, 5'd12, '1, 32'h0040_0000);
        push("rst_count_rd",  SEL_READ, 5'd9,  '1, 32'h0);
        push("rst_cause_rd",  SEL_READ, 5'd13, '1, 32'h0);
        push("rst_epc_rd",    SEL_READ, 5'd14, '1, 32'h0);
        push("rst_tint",      SEL_TINT, 5'd0,  '1, 32'h0);
        push("prid_rd",       SEL_READ, 5'd15, '1, 32'h0000_4220);
        push("config_rd",     SEL_READ, 5'd16, '1, 32'h0000_8000);
        drain();

        // Timer match
        mtc0(5'd11, 32'd10);
        mtc0(5'd9, 32'd0);
        n = 0;
        while (!timer_int_o && n < 60) begin
            step();
            n++;
        end
        push("tint_rise",     SEL_TINT,  5'd0, '1, 32'h1);
        push("tint_count",    SEL_COUNT, 5'd0, '1, 32'd10);
        drain();
        step();
        push("cause_ip7",     SEL_CAUSE, 5'd0, 32'h0000_FC00, 32'h0000_8000);
        push("tint_sticky",   SEL_TINT,  5'd0, '1, 32'h1);
        drain();
        we_i = 1'b1; waddr_i = 5'd11; data_i = 32'd50;
        push("cmp_bypass",    SEL_READ, 5'd11, '1, 32'd50);
        drain();
        step();
        we_i = 1'b0;
        push("tint_clear",    SEL_TINT, 5'd0, '1, 32'h0);
        push("cmp_val",       SEL_CMP,  5'd0, '1, 32'd50);
        drain();

        // OV in delay slot
        except(32'h0000_000c, 32'hbfc0_1000, 1'b1, 32'h0);
        push("ov_epc",        SEL_EPC,    5'd0,  '1, 32'hbfc0_0ffc);
        push("ov_epc_rd",     SEL_READ,   5'd14, '1, 32'hbfc0_0ffc);
        push("ov_cause",      SEL_CAUSE,  5'd0,  32'h8000_007C, 32'h8000_0030);
        push("ov_exl",        SEL_STATUS, 5'd0,  32'h0000_0002, 32'h0000_0002);
        drain();

        // Nested SYS then ERET
        except(32'h0000_0008, 32'h8000_0100, 1'b0, 32'h0);
        push("sys_epc_hold",  SEL_EPC,   5'd0, '1, 32'hbfc0_0ffc);
        push("sys_cause",     SEL_CAUSE, 5'd0, 32'h8000_007C, 32'h8000_0020);
        drain();
        except(32'h0000_000e, 32'h0, 1'b0, 32'h0);
        push("eret_status",   SEL_STATUS, 5'd0, '1, 32'h0040_0000);
        push("eret_epc",      SEL_EPC,    5'd0, '1, 32'hbfc0_0ffc);
        drain();

        // ADEL with a flushed mtc0 Status
        mtc0(5'd12, 32'h0000_0401);
        push("status_wr",     SEL_STATUS, 5'd0, '1, 32'h0040_0401);
        drain();
        we_i = 1'b1; waddr_i = 5'd12; data_i = 32'h0;
        except(32'h0000_0004, 32'h8000_0200, 1'b0, 32'h0000_0003);
        we_i = 1'b0;
        push("adel_badv",     SEL_BADV,   5'd0, '1, 32'h0000_0003);
        push("adel_status",   SEL_STATUS, 5'd0, '1, 32'h0040_0403);
        push("adel_epc",      SEL_EPC,    5'd0, '1, 32'h8000_0200);
        push("adel_cause",    SEL_CAUSE,  5'd0, 32'h8000_007C, 32'h0000_0010);
        drain();
        except(32'h0000_000e, 32'h0, 1'b0, 32'h0);
        push("eret2_status",  SEL_STATUS, 5'd0, '1, 32'h0040_0401);
        drain();

        // Status all-ones with same-cycle read
        we_i = 1'b1; waddr_i = 5'd12; data_i = 32'hFFFF_FFFF;
        push("status_bypass", SEL_READ, 5'd12, '1, 32'h0040_FF03);
        drain();
        step();
        we_i = 1'b0;
        push("status_ones",   SEL_STATUS, 5'd0, '1, 32'h0040_FF03);
        drain();

        // Cause software IP, unmapped register, Count wrap
        mtc0(5'd13, 32'hFFFF_FFFF);
        push("cause_sw_ip",   SEL_CAUSE, 5'd0, 32'h0000_037C, 32'h0000_0310);
        drain();
        mtc0(5'd3, 32'hDEAD_BEEF);
        push("unmapped_rd",   SEL_READ, 5'd3, '1, 32'h0);
        drain();
        mtc0(5'd9, 32'hFFFF_FFFF);
        n = 0;
        while (count_o == 32'hFFFF_FFFF && n < 4) begin
            step();
            n++;
        end
        push("count_wrap",    SEL_COUNT, 5'd0, '1, 32'h0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
